// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV control path: FSM states, opcodes,
// datapath select codes and the bundled control word.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8
    } state_t;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_REG   = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Every strobe and select the FSM drives, gathered so one assignment
    // can clear the whole set.
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       addr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LD) || (op == OP_SD);
    endfunction

    function automatic logic is_supported(input logic [6:0] op);
        return is_mem_op(op) || (op == OP_RTYPE) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control FSM (master) and the multicycle datapath (slave).
interface multicycle_control_if;
    import multicycle_pkg::*;

    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       addr_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ALUOp;
    logic [1:0] result_src;
    logic       instr_done;
    logic       illegal_op;
    state_t     state;

    // Memory handshake: mem_read/mem_write form a request that stays asserted,
    // with addr_src and all selects unchanged, until a rising edge that sees
    // mem_ready=1; that edge completes the access and the request drops.
    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, ir_write, addr_src, mem_read, mem_write, reg_write,
        output alu_src_a, alu_src_b, ALUOp, result_src,
        output instr_done, illegal_op, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, ir_write, addr_src, mem_read, mem_write, reg_write,
        input  alu_src_a, alu_src_b, ALUOp, result_src,
        input  instr_done, illegal_op, state
    );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV datapath: sequences fetch, decode,
// execute, memory and writeback, stalling on the single-ported memory.
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctrl    = '0;

        case (state_q)
            FETCH: begin
                ctrl.addr_src   = 1'b0;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src_a  = SRC_A_PC;
                ctrl.alu_src_b  = SRC_B_FOUR;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.result_src = RES_ALU;
                ctrl.ir_write   = bus.mem_ready;
                ctrl.pc_write   = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = DECODE;
                end
            end

            // The adder is otherwise idle here, so it precomputes the branch
            // target into ALUOut for BRANCH to consume.
            DECODE: begin
                ctrl.alu_src_a = SRC_A_OLDPC;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                if (is_mem_op(bus.opcode)) begin
                    state_d = MEM_ADDR;
                end else if (bus.opcode == OP_RTYPE) begin
                    state_d = EXEC_R;
                end else if (bus.opcode == OP_BEQ) begin
                    state_d = BRANCH;
                end else begin
                    state_d         = FETCH;
                    ctrl.illegal_op = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
            end

            MEM_ADDR: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_d        = (bus.opcode == OP_SD) ? MEM_WRITE : MEM_READ;
            end

            MEM_READ: begin
                ctrl.addr_src   = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_read   = 1'b1;
                if (bus.mem_ready) begin
                    state_d = MEM_WB;
                end
            end

            MEM_WB: begin
                ctrl.result_src = RES_MDR;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end

            MEM_WRITE: begin
                ctrl.addr_src   = 1'b1;
                ctrl.result_src = RES_ALUOUT;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = FETCH;
                end
            end

            EXEC_R: begin
                ctrl.alu_src_a = SRC_A_REG;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_d        = ALU_WB;
            end

            ALU_WB: begin
                ctrl.result_src = RES_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end

            BRANCH: begin
                ctrl.alu_src_a  = SRC_A_REG;
                ctrl.alu_src_b  = SRC_B_REG;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.result_src = RES_ALUOUT;
                ctrl.pc_write   = bus.zero;
                ctrl.instr_done = 1'b1;
                state_d         = FETCH;
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // A reset cycle must never leak a strobe, whatever state it lands in.
        if (reset) begin
            ctrl = '0;
        end
    end

    assign bus.pc_write   = ctrl.pc_write;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.addr_src   = ctrl.addr_src;
    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.ALUOp      = ctrl.alu_op;
    assign bus.result_src = ctrl.result_src;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.illegal_op = ctrl.illegal_op;
    assign bus.state      = state_q;

    a_no_rw_mw: assert property (@(posedge clk) !(bus.reg_write && bus.mem_write));

    // A stalled request keeps the same address and selects on the next cycle.
    a_stall_hold: assert property (@(posedge clk) disable iff (reset)
        ((bus.mem_read || bus.mem_write) && !bus.mem_ready) |=>
            (reset || ($stable(bus.mem_read) && $stable(bus.mem_write) &&
                       $stable(bus.addr_src) && $stable(bus.alu_src_a) &&
                       $stable(bus.alu_src_b) && $stable(bus.result_src))));

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: per-cycle hand-computed
// control words and states for each instruction class, stalls and reset.
module tb_multicycle_control;
    import multicycle_pkg::*;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [15:0] ow(
        input logic pcw, input logic irw, input logic as, input logic mr,
        input logic mw, input logic rw, input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] op, input logic [1:0] rs, input logic done, input logic ill);
        return {pcw, irw, as, mr, mw, rw, a, b, op, rs, done, ill};
    endfunction

    logic [15:0] outs;
    assign outs = {bus.pc_write, bus.ir_write, bus.addr_src, bus.mem_read,
                   bus.mem_write, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                   bus.ALUOp, bus.result_src, bus.instr_done, bus.illegal_op};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are applied just after a rising edge and checked on the falling edge.
    task automatic cyc(input string tag, input logic [6:0] op, input logic z,
                       input logic rdy, input state_t exp_st, input logic [15:0] exp_o);
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = rdy;
        @(negedge clk);
        check_eq({tag, "_st"}, 32'(bus.state), 32'(exp_st));
        check_eq({tag, "_out"}, 32'(outs), 32'(exp_o));
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc(input string tag, input logic rdy);
        reset         = 1'b1;
        bus.mem_ready = rdy;
        bus.zero      = 1'b1;
        @(negedge clk);
        check_eq(tag, 32'(outs), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- expected control words ----------------
    localparam logic [15:0] E_FETCH   = 16'b1_1_0_1_0_0_00_01_00_10_0_0;
    localparam logic [15:0] E_FETCH_W = 16'b0_0_0_1_0_0_00_01_00_10_0_0;
    localparam logic [15:0] E_DECODE  = 16'b0_0_0_0_0_0_01_10_00_00_0_0;
    localparam logic [15:0] E_ILLEGAL = 16'b0_0_0_0_0_0_01_10_00_00_1_1;
    localparam logic [15:0] E_MADDR   = 16'b0_0_0_0_0_0_10_10_00_00_0_0;
    localparam logic [15:0] E_MREAD   = 16'b0_0_1_1_0_0_00_00_00_00_0_0;
    localparam logic [15:0] E_MWB     = 16'b0_0_0_0_0_1_00_00_00_01_1_0;
    localparam logic [15:0] E_MWR     = 16'b0_0_1_0_1_0_00_00_00_00_1_0;
    localparam logic [15:0] E_MWR_W   = 16'b0_0_1_0_1_0_00_00_00_00_0_0;
    localparam logic [15:0] E_EXEC    = 16'b0_0_0_0_0_0_10_00_10_00_0_0;
    localparam logic [15:0] E_ALUWB   = 16'b0_0_0_0_0_1_00_00_00_00_1_0;
    localparam logic [15:0] E_BR_T    = 16'b1_0_0_0_0_0_10_00_01_00_1_0;
    localparam logic [15:0] E_BR_N    = 16'b0_0_0_0_0_0_10_00_01_00_1_0;

    localparam logic [6:0] OP_BAD = 7'b1111111;

    // ---------------- stimulus + checks ----------------
    initial begin
        n_total       = 0;
        n_bad         = 0;
        reset         = 1'b1;
        bus.opcode    = OP_RTYPE;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_cyc("por_outs", 1'b1);

        // helper sanity: table constant agrees with field-wise construction
        check_eq("fetch_word", 32'(E_FETCH),
                 32'(ow(1, 1, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b10, 0, 0)));

        // R-type, memory always ready: 4 cycles
        cyc("r_f",  OP_RTYPE, 0, 1, FETCH,  E_FETCH);
        cyc("r_d",  OP_RTYPE, 0, 1, DECODE, E_DECODE);
        cyc("r_ex", OP_RTYPE, 0, 1, EXEC_R, E_EXEC);
        cyc("r_wb", OP_RTYPE, 0, 1, ALU_WB, E_ALUWB);

        // ld with two wait cycles in MEM_READ: writeback in cycle 7
        cyc("ld_f",  OP_LD, 0, 1, FETCH,    E_FETCH);
        cyc("ld_d",  OP_LD, 0, 1, DECODE,   E_DECODE);
        cyc("ld_ma", OP_LD, 0, 1, MEM_ADDR, E_MADDR);
        cyc("ld_r0", OP_LD, 0, 0, MEM_READ, E_MREAD);
        cyc("ld_r1", OP_LD, 0, 0, MEM_READ, E_MREAD);
        cyc("ld_r2", OP_LD, 0, 1, MEM_READ, E_MREAD);
        cyc("ld_wb", OP_LD, 0, 1, MEM_WB,   E_MWB);

        // beq taken then not taken
        cyc("bt_f",  OP_BEQ, 1, 1, FETCH,  E_FETCH);
        cyc("bt_d",  OP_BEQ, 1, 1, DECODE, E_DECODE);
        cyc("bt_br", OP_BEQ, 1, 1, BRANCH, E_BR_T);
        cyc("bn_f",  OP_BEQ, 0, 1, FETCH,  E_FETCH);
        cyc("bn_d",  OP_BEQ, 0, 1, DECODE, E_DECODE);
        cyc("bn_br", OP_BEQ, 0, 1, BRANCH, E_BR_N);

        // sd with one fetch wait, then an illegal opcode
        cyc("sd_fw", OP_SD, 0, 0, FETCH,     E_FETCH_W);
        cyc("sd_f",  OP_SD, 0, 1, FETCH,     E_FETCH);
        cyc("sd_d",  OP_SD, 0, 1, DECODE,    E_DECODE);
        cyc("sd_ma", OP_SD, 0, 1, MEM_ADDR,  E_MADDR);
        cyc("sd_mw", OP_SD, 0, 1, MEM_WRITE, E_MWR);
        cyc("il_f",  OP_BAD, 0, 1, FETCH,    E_FETCH);
        cyc("il_d",  OP_BAD, 0, 1, DECODE,   E_ILLEGAL);

        // sd with one wait cycle in MEM_WRITE: instr_done only on completion
        cyc("sw_f",  OP_SD, 0, 1, FETCH,     E_FETCH);
        cyc("sw_d",  OP_SD, 0, 1, DECODE,    E_DECODE);
        cyc("sw_ma", OP_SD, 0, 1, MEM_ADDR,  E_MADDR);
        cyc("sw_w0", OP_SD, 0, 0, MEM_WRITE, E_MWR_W);
        cyc("sw_w1", OP_SD, 0, 1, MEM_WRITE, E_MWR);

        // reset held 3 cycles in the middle of an R-type instruction
        cyc("rr_f",  OP_RTYPE, 0, 1, FETCH,  E_FETCH);
        cyc("rr_d",  OP_RTYPE, 0, 1, DECODE, E_DECODE);
        cyc("rr_ex", OP_RTYPE, 0, 1, EXEC_R, E_EXEC);
        reset = 1'b1;
        rst_cyc("rst_0", 1'b1);
        reset = 1'b1;
        rst_cyc("rst_1", 1'b1);
        reset = 1'b1;
        rst_cyc("rst_2", 1'b1);
        cyc("rr_post", OP_RTYPE, 0, 1, FETCH, E_FETCH);

        // reset while stalled in MEM_READ aborts the load
        cyc("ra_d",  OP_LD, 0, 1, DECODE,   E_DECODE);
        cyc("ra_ma", OP_LD, 0, 1, MEM_ADDR, E_MADDR);
        cyc("ra_r0", OP_LD, 0, 0, MEM_READ, E_MREAD);
        rst_cyc("ra_rst", 1'b1);
        cyc("ra_post", OP_LD, 0, 0, FETCH, E_FETCH_W);

        // ---------------- final report ----------------
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
